// File: rtl/axi4_lite_slv_template_if.sv
// axi4_lite_if: AXI4-Lite bus bundle with master and slave views
interface axi4_lite_if #(
    parameter int ADDR_BIT_WIDTH = 32,
    parameter int DATA_BIT_WIDTH = 32
);
    logic [ADDR_BIT_WIDTH-1:0]   awaddr;
    logic [2:0]                  awprot;
    logic                        awvalid;
    logic                        awready;
    logic [DATA_BIT_WIDTH-1:0]   wdata;
    logic [DATA_BIT_WIDTH/8-1:0] wstrb;
    logic                        wvalid;
    logic                        wready;
    logic [1:0]                  bresp;
    logic                        bvalid;
    logic                        bready;
    logic [ADDR_BIT_WIDTH-1:0]   araddr;
    logic [2:0]                  arprot;
    logic                        arvalid;
    logic                        arready;
    logic [DATA_BIT_WIDTH-1:0]   rdata;
    logic [1:0]                  rresp;
    logic                        rvalid;
    logic                        rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4_lite_slv_template.sv
// axi4_lite_slv_template: AXI4-Lite slave with NUM_REGS byte-writable 32-bit registers
module axi4_lite_slv_template #(
    parameter int ADDR_BIT_WIDTH = 32,
    parameter int DATA_BIT_WIDTH = 32,
    parameter int NUM_REGS       = 4
) (
    input logic       i_clk,
    input logic       i_sync_rst,
    axi4_lite_if.slave if_s_axi4_lite
);
    localparam int IW = $clog2(NUM_REGS);
    localparam int NB = DATA_BIT_WIDTH / 8;

    logic [DATA_BIT_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_BIT_WIDTH-1:0] regs_d [NUM_REGS];
    logic                      aw_rdy_q, aw_rdy_d, bvalid_q, bvalid_d;
    logic                      ar_rdy_q, ar_rdy_d, rvalid_q, rvalid_d;
    logic [IW-1:0]             ar_idx_q, ar_idx_d, aw_idx;
    logic [DATA_BIT_WIDTH-1:0] rdata_q, rdata_d;
    logic                      unused_bits;

    assign aw_idx = if_s_axi4_lite.awaddr[IW+1:2];
    assign unused_bits = ^{if_s_axi4_lite.awprot, if_s_axi4_lite.arprot,
                           if_s_axi4_lite.awaddr[ADDR_BIT_WIDTH-1:IW+2], if_s_axi4_lite.awaddr[1:0],
                           if_s_axi4_lite.araddr[ADDR_BIT_WIDTH-1:IW+2], if_s_axi4_lite.araddr[1:0]};

    assign if_s_axi4_lite.awready = aw_rdy_q;
    assign if_s_axi4_lite.wready  = aw_rdy_q;
    assign if_s_axi4_lite.bvalid  = bvalid_q;
    assign if_s_axi4_lite.bresp   = 2'b00;
    assign if_s_axi4_lite.arready = ar_rdy_q;
    assign if_s_axi4_lite.rvalid  = rvalid_q;
    assign if_s_axi4_lite.rdata   = rdata_q;
    assign if_s_axi4_lite.rresp   = 2'b00;

    // Handshake next-state for both channels; reads sample regs_q so a same-edge write is not visible
    always_comb begin
        aw_rdy_d = !aw_rdy_q && !bvalid_q && if_s_axi4_lite.awvalid && if_s_axi4_lite.wvalid;
        bvalid_d = aw_rdy_q || (bvalid_q && !if_s_axi4_lite.bready);
        ar_rdy_d = !ar_rdy_q && !rvalid_q && if_s_axi4_lite.arvalid;
        ar_idx_d = ar_rdy_d ? if_s_axi4_lite.araddr[IW+1:2] : ar_idx_q;
        rvalid_d = ar_rdy_q || (rvalid_q && !if_s_axi4_lite.rready);
        rdata_d  = ar_rdy_q ? regs_q[ar_idx_q] : rdata_q;
        regs_d   = regs_q;
        for (int i = 0; i < NB; i++)
            if (aw_rdy_q && if_s_axi4_lite.wstrb[i])
                regs_d[aw_idx][8*i +: 8] = if_s_axi4_lite.wdata[8*i +: 8];
    end

    // State registers with reset dropping any in-flight transaction
    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            regs_q   <= '{default: '0};
            aw_rdy_q <= 1'b0;
            bvalid_q <= 1'b0;
            ar_rdy_q <= 1'b0;
            rvalid_q <= 1'b0;
            ar_idx_q <= '0;
            rdata_q  <= '0;
        end else begin
            regs_q   <= regs_d;
            aw_rdy_q <= aw_rdy_d;
            bvalid_q <= bvalid_d;
            ar_rdy_q <= ar_rdy_d;
            rvalid_q <= rvalid_d;
            ar_idx_q <= ar_idx_d;
            rdata_q  <= rdata_d;
        end
    end
endmodule

// File: tb/tb_axi4_lite_slv_template.sv
// tb_axi4_lite_slv_template: directed vector bench for the AXI4-Lite register slave
module tb_axi4_lite_slv_template;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;

    axi4_lite_if #(.ADDR_BIT_WIDTH(32), .DATA_BIT_WIDTH(32)) bus ();

    axi4_lite_slv_template #(.ADDR_BIT_WIDTH(32), .DATA_BIT_WIDTH(32), .NUM_REGS(4)) dut (
        .i_clk(clk),
        .i_sync_rst(rst),
        .if_s_axi4_lite(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic finish_write(input bit best);
        int k;
        for (k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (bus.awready) break;
        end
        chk("awready", 32'(bus.awready), 1);
        chk("wready", 32'(bus.wready), 1);
        if (best) chk("aw_latency", k, 1);
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        chk("awready_one_cycle", 32'(bus.awready), 0);
        chk("wready_one_cycle", 32'(bus.wready), 0);
        chk("bvalid", 32'(bus.bvalid), 1);
        chk("bresp", 32'(bus.bresp), 0);
        if (bus.bready) begin
            @(posedge clk); #1;
            chk("bvalid_clear", 32'(bus.bvalid), 0);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.awaddr  = a;
        bus.wdata   = d;
        bus.wstrb   = s;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        finish_write(1'b1);
    endtask

    task automatic finish_read(input logic [31:0] exp, input bit best);
        int k;
        for (k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (bus.arready) break;
        end
        chk("arready", 32'(bus.arready), 1);
        if (best) chk("ar_latency", k, 1);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        chk("arready_one_cycle", 32'(bus.arready), 0);
        chk("rvalid", 32'(bus.rvalid), 1);
        chk("rresp", 32'(bus.rresp), 0);
        chk("rdata", bus.rdata, exp);
        if (bus.rready) begin
            @(posedge clk); #1;
            chk("rvalid_clear", 32'(bus.rvalid), 0);
        end
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp);
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        finish_read(exp, 1'b1);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 32'h00, 32'h12345678, 4'hF, 32'h0};
        tbl[1]  = '{1'b1, 32'h04, 32'h87654321, 4'hF, 32'h0};
        tbl[2]  = '{1'b1, 32'h08, 32'hABCDEF01, 4'hF, 32'h0};
        tbl[3]  = '{1'b1, 32'h0C, 32'h10FEDCBA, 4'hF, 32'h0};
        tbl[4]  = '{1'b0, 32'h00, 32'h0, 4'h0, 32'h12345678};
        tbl[5]  = '{1'b0, 32'h04, 32'h0, 4'h0, 32'h87654321};
        tbl[6]  = '{1'b0, 32'h08, 32'h0, 4'h0, 32'hABCDEF01};
        tbl[7]  = '{1'b0, 32'h0C, 32'h0, 4'h0, 32'h10FEDCBA};
        tbl[8]  = '{1'b1, 32'h04, 32'hFFFFFFFF, 4'b0101, 32'h0};
        tbl[9]  = '{1'b0, 32'h04, 32'h0, 4'h0, 32'h87FF43FF};
        tbl[10] = '{1'b0, 32'h10, 32'h0, 4'h0, 32'h12345678};
        tbl[11] = '{1'b0, 32'h1C, 32'h0, 4'h0, 32'h10FEDCBA};
        tbl[12] = '{1'b0, 32'h03, 32'h0, 4'h0, 32'h12345678};
        tbl[13] = '{1'b1, 32'h08, 32'h00000000, 4'h0, 32'h0};
        tbl[14] = '{1'b0, 32'h08, 32'h0, 4'h0, 32'hABCDEF01};

        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b1;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;

        repeat (20) @(posedge clk);
        #1;
        chk("rst_awready", 32'(bus.awready), 0);
        chk("rst_bvalid", 32'(bus.bvalid), 0);
        chk("rst_arready", 32'(bus.arready), 0);
        chk("rst_rvalid", 32'(bus.rvalid), 0);
        chk("rst_rdata", bus.rdata, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) do_read(32'(4 * i), 32'h0);

        for (int i = 0; i < 15; i++) begin
            if (tbl[i].wr) do_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
            else do_read(tbl[i].addr, tbl[i].exp);
        end

        // write backpressure: second write must wait for bready
        bus.bready = 1'b0;
        do_write(32'h0, 32'hAAAA5555, 4'hF);
        bus.awaddr = 32'h8; bus.wdata = 32'h11112222; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_awready", 32'(bus.awready), 0);
            chk("bp_bvalid", 32'(bus.bvalid), 1);
        end
        bus.bready = 1'b1;
        finish_write(1'b0);
        do_read(32'h0, 32'hAAAA5555);

        // read backpressure: rdata holds, second read waits for rready
        bus.rready = 1'b0;
        do_read(32'h0, 32'hAAAA5555);
        bus.araddr = 32'h8; bus.arvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_arready", 32'(bus.arready), 0);
            chk("bp_rvalid", 32'(bus.rvalid), 1);
            chk("bp_rdata", bus.rdata, 32'hAAAA5555);
        end
        bus.rready = 1'b1;
        finish_read(32'h11112222, 1'b0);

        // concurrent read and write to the same register returns the old value
        bus.awaddr = 32'hC; bus.wdata = 32'h55AA55AA; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        bus.araddr = 32'hC; bus.arvalid = 1'b1;
        @(posedge clk); #1;
        chk("co_awready", 32'(bus.awready), 1);
        chk("co_arready", 32'(bus.arready), 1);
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        chk("co_bvalid", 32'(bus.bvalid), 1);
        chk("co_rvalid", 32'(bus.rvalid), 1);
        chk("co_rdata", bus.rdata, 32'h10FEDCBA);
        @(posedge clk); #1;
        do_read(32'hC, 32'h55AA55AA);

        // reset while bvalid and arready are both high
        bus.bready = 1'b0;
        do_write(32'h4, 32'hDEADBEEF, 4'hF);
        bus.araddr = 32'h4; bus.arvalid = 1'b1;
        @(posedge clk); #1;
        chk("pre_rst_arready", 32'(bus.arready), 1);
        chk("pre_rst_bvalid", 32'(bus.bvalid), 1);
        rst = 1'b1; bus.arvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; bus.bready = 1'b1;
        chk("mid_rst_awready", 32'(bus.awready), 0);
        chk("mid_rst_wready", 32'(bus.wready), 0);
        chk("mid_rst_bvalid", 32'(bus.bvalid), 0);
        chk("mid_rst_arready", 32'(bus.arready), 0);
        chk("mid_rst_rvalid", 32'(bus.rvalid), 0);
        chk("mid_rst_rdata", bus.rdata, 0);
        @(posedge clk); #1;
        chk("post_rst_rvalid", 32'(bus.rvalid), 0);
        for (int i = 0; i < 4; i++) do_read(32'(4 * i), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
